// File: rtl/dino_jump_if.sv
`default_nettype none
// ============================================================================
// Module   : dino_jump_if
// Purpose  : Bundles the frame-tick / control inputs and the sprite outputs
//            of the T-Rex jump engine.
// Ports    : frame_tick, jump, duck      (master -> slave)
//            y, state, airborne, ducking, landed (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface dino_jump_if #(
  parameter int Y_W = 11
);
  logic           frame_tick;
  logic           jump;
  logic           duck;
  logic [Y_W-1:0] y;
  logic [1:0]     state;
  logic           airborne;
  logic           ducking;
  logic           landed;

  modport master (
    output frame_tick, jump, duck,
    input  y, state, airborne, ducking, landed
  );

  modport slave (
    input  frame_tick, jump, duck,
    output y, state, airborne, ducking, landed
  );
endinterface
`default_nettype wire

// File: rtl/dino_jump_engine.sv
`default_nettype none
// ============================================================================
// Module   : dino_jump_engine
// Purpose  : Frame-stepped vertical physics and posture controller for the
//            T-Rex sprite. Updates happen only on frame_tick.
// Ports    : clk        - system clock
//            rst        - synchronous active-high reset
//            bus.slave  - frame_tick/jump/duck in; y/state/airborne/
//                         ducking/landed out (all outputs registered)
// Options  : DINO_DOUBLE_JUMP_EN - allows one extra jump while airborne
// Revision : 1.0 - initial release
// ============================================================================
module dino_jump_engine #(
  parameter int Y_W      = 11,
  parameter int GROUND_Y = 300,
  parameter int Y_MIN    = 0,
  parameter int V0       = 20,
  parameter int G        = 1,
  parameter int G_FAST   = 3,
  parameter int V_MAX    = 20
) (
  input  wire logic clk,
  input  wire logic rst,
  dino_jump_if.slave bus
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_DUCK   = 2'd3
  } state_t;

  // Signed constants at the Y_W+2 working width so the comparisons against
  // a possibly negative position sum stay signed.
  localparam logic signed [Y_W+1:0] GROUND_S = (Y_W+2)'(GROUND_Y);
  localparam logic signed [Y_W+1:0] YMIN_S   = (Y_W+2)'(Y_MIN);
  localparam logic signed [Y_W+1:0] VMAX_S   = (Y_W+2)'(V_MAX);
  localparam logic signed [Y_W+1:0] G_S      = (Y_W+2)'(G);
  localparam logic signed [Y_W+1:0] GF_S     = (Y_W+2)'(G_FAST);
  localparam logic signed [Y_W:0]   VMAX_V   = (Y_W+1)'(V_MAX);
  localparam logic signed [Y_W:0]   VEL_JUMP = -((Y_W+1)'(V0));
  localparam logic [Y_W-1:0]        GROUND_Y_V = Y_W'(GROUND_Y);
  localparam logic [Y_W-1:0]        YMIN_Y_V   = Y_W'(Y_MIN);

  state_t                st;
  logic [Y_W-1:0]        y_r;
  logic signed [Y_W:0]   vel;
  logic                  jump_prev;
  logic                  jump_req;
  logic                  airborne_r;
  logic                  ducking_r;
  logic                  landed_r;
`ifdef DINO_DOUBLE_JUMP_EN
  logic                  air_jump_used;
  logic                  aju_nx;
`endif

  state_t                st_nx;
  logic [Y_W-1:0]        y_nx;
  logic signed [Y_W:0]   vel_nx;
  logic                  land_nx;
  logic                  airborne_nx;
  logic                  jump_rise;
  logic signed [Y_W+1:0] sum;
  logic signed [Y_W+1:0] vel_inc;

  assign jump_rise   = bus.jump & ~jump_prev;
  assign sum         = $signed({2'b00, y_r}) + $signed({vel[Y_W], vel});
  assign vel_inc     = $signed({vel[Y_W], vel}) + (bus.duck ? GF_S : G_S);
  assign airborne_nx = (st_nx == ST_RISE) || (st_nx == ST_FALL);

  always_comb begin
    st_nx   = st;
    y_nx    = y_r;
    vel_nx  = vel;
    land_nx = 1'b0;
`ifdef DINO_DOUBLE_JUMP_EN
    aju_nx  = air_jump_used;
`endif
    if (bus.frame_tick) begin
      case (st)
        ST_GROUND: begin
          // A pending jump beats a simultaneous duck.
          if (jump_req) begin
            vel_nx = VEL_JUMP;
            st_nx  = ST_RISE;
          end else if (bus.duck) begin
            st_nx = ST_DUCK;
          end
        end
        ST_DUCK: begin
          if (!bus.duck) st_nx = ST_GROUND;
        end
        default: begin
`ifdef DINO_DOUBLE_JUMP_EN
          if (jump_req && !air_jump_used) begin
            vel_nx = VEL_JUMP;
            st_nx  = ST_RISE;
            aju_nx = 1'b1;
          end else
`endif
          if (sum >= GROUND_S) begin
            y_nx    = GROUND_Y_V;
            vel_nx  = '0;
            st_nx   = ST_GROUND;
            land_nx = 1'b1;
`ifdef DINO_DOUBLE_JUMP_EN
            aju_nx  = 1'b0;
`endif
          end else begin
            if (sum < YMIN_S) y_nx = YMIN_Y_V;
            else              y_nx = sum[Y_W-1:0];
            // Terminal velocity saturation on the way down.
            vel_nx = (vel_inc > VMAX_S) ? VMAX_V : vel_inc[Y_W:0];
            if ((st == ST_RISE) && !vel_nx[Y_W]) st_nx = ST_FALL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_GROUND;
      y_r        <= GROUND_Y_V;
      vel        <= '0;
      jump_prev  <= 1'b0;
      jump_req   <= 1'b0;
      airborne_r <= 1'b0;
      ducking_r  <= 1'b0;
      landed_r   <= 1'b0;
`ifdef DINO_DOUBLE_JUMP_EN
      air_jump_used <= 1'b0;
`endif
    end else begin
      jump_prev  <= bus.jump;
      // Every tick consumes or drops the request; a new edge in the same
      // cycle still leaves it set.
      jump_req   <= jump_rise | (jump_req & ~bus.frame_tick);
      st         <= st_nx;
      y_r        <= y_nx;
      vel        <= vel_nx;
      airborne_r <= airborne_nx;
      ducking_r  <= (st_nx == ST_DUCK) | (airborne_nx & bus.duck);
      landed_r   <= land_nx;
`ifdef DINO_DOUBLE_JUMP_EN
      air_jump_used <= aju_nx;
`endif
    end
  end

  assign bus.y        = y_r;
  assign bus.state    = st;
  assign bus.airborne = airborne_r;
  assign bus.ducking  = ducking_r;
  assign bus.landed   = landed_r;

endmodule
`default_nettype wire
